freq_gate_ctrl: RTL and testbench

Measurement sequencer for the frequency counter. Opens and closes the counting gate from the 1 µs timebase strobe, and gates input edges into the BCD edge counter. Issues that counter's clear and latch pulses, and selects the gate time (10 ms, 100 ms, 1 s or 10 s at the default parameter). It sits between the timebase prescaler and the BCD counter/display mux, replacing the fixed 1 s latch/reset logic in the top level.

---
 rtl/freq_gate_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - measurement sequencer for the frequency counter gate
//
// Purpose:
//   Opens and closes the counting gate from the 1 us timebase strobe.
//   Gates input edges into the BCD edge counter.
//   Issues that counter's clear and latch pulses.
//   Selects the gate time: GATE_BASE * 10^range ticks, range 0..3.
//
// Optional feature:
//   FREQ_GATE_AUTORANGE_EN - when defined, the gate range comes from an internal
//   auto-range register updated at every latch, and range_sel is ignored.
//   When undefined, the range is range_sel sampled in CLEAR, and ctr_msd_zero
//   is unused.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   tick_1us      in   one-cycle strobe per microsecond
//   sig_edge      in   one-cycle pulse per synchronized rising edge of the input
//   run           in   level, high = continuous measurement
//   range_sel     in   manual gate range 0..3
//   ctr_carry     in   BCD counter carry-out (overflow)
//   ctr_msd_zero  in   most significant live BCD digit is zero
//   cnt_en        out  registered count enable to the BCD counter
//   ctr_clear     out  one-cycle clear to the BCD counter
//   ctr_latch     out  one-cycle latch strobe to the BCD counter
//   gate_open     out  high while the gate is open
//   range         out  range of the displayed result
//   ovf           out  displayed result overflowed
//   busy          out  high in any state except IDLE
module freq_gate_ctrl #(
  parameter int GATE_BASE  = 10000,
  parameter int HOLD_TICKS = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1us,
  input  logic       sig_edge,
  input  logic       run,
  input  logic [1:0] range_sel,
  input  logic       ctr_carry,
  input  logic       ctr_msd_zero,
  output logic       cnt_en,
  output logic       ctr_clear,
  output logic       ctr_latch,
  output logic       gate_open,
  output logic [1:0] range,
  output logic       ovf,
  output logic       busy
);

  localparam int BASE_W = (GATE_BASE > 1) ? $clog2(GATE_BASE) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(GATE_BASE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_GATE, S_LATCH, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [2:0][3:0]   dec_q, dec_d, dec_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        act_q, act_d;
  logic [1:0]        range_q, range_d;
  logic              sticky_q, sticky_d;
  logic              ovf_q, ovf_d;
  logic              cnt_en_q;
  logic              dec_last;

`ifdef FREQ_GATE_AUTORANGE_EN
  logic [1:0] auto_q, auto_d;
  logic [1:0] unused_range_sel;
  assign unused_range_sel = range_sel;
`else
  logic unused_msd_zero;
  assign unused_msd_zero = ctr_msd_zero;
`endif

  // Decade counting is done as three cascaded BCD digits so that range 3
  // (1000 base wraps) fits; digits at or above the active range never move.
  always_comb begin
    logic carry_c;
    dec_inc = dec_q;
    carry_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry_c) begin
        if (dec_q[i] == 4'd9) begin
          dec_inc[i] = 4'd0;
        end else begin
          dec_inc[i] = dec_q[i] + 4'd1;
          carry_c    = 1'b0;
        end
      end
    end
  end

  // All digits below the active range at 9 means 10^range - 1 wraps done.
  always_comb begin
    dec_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(act_q) && dec_q[i] != 4'd9) dec_last = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    dec_d    = dec_q;
    hold_d   = hold_q;
    act_d    = act_q;
    range_d  = range_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
`ifdef FREQ_GATE_AUTORANGE_EN
    auto_d   = auto_q;
`endif
    case (state_q)
      S_IDLE: if (run) state_d = S_CLEAR;
      S_CLEAR: begin
`ifdef FREQ_GATE_AUTORANGE_EN
        act_d = auto_q;
`else
        act_d = range_sel;
`endif
        sticky_d = 1'b0;
        state_d  = S_ARM;
      end
      S_ARM: begin
        if (tick_1us) begin
          base_d  = '0;
          dec_d   = '0;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (ctr_carry) sticky_d = 1'b1;
        if (tick_1us) begin
          if (base_q == BASE_LAST) begin
            base_d = '0;
            if (dec_last) state_d = S_LATCH;
            else          dec_d   = dec_inc;
          end else begin
            base_d = base_q + 1'b1;
          end
        end
      end
      S_LATCH: begin
        // The carry may arrive together with the final counted edge.
        ovf_d   = sticky_q | ctr_carry;
        range_d = act_q;
        hold_d  = '0;
`ifdef FREQ_GATE_AUTORANGE_EN
        if ((sticky_q | ctr_carry) && auto_q != 2'd0) auto_d = auto_q - 2'd1;
        else if (ctr_msd_zero && auto_q != 2'd3)      auto_d = auto_q + 2'd1;
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (tick_1us) begin
          if (hold_q == HOLD_LAST) state_d = run ? S_CLEAR : S_IDLE;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      dec_q    <= '0;
      hold_q   <= '0;
      act_q    <= 2'd0;
      range_q  <= 2'd0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_en_q <= 1'b0;
`ifdef FREQ_GATE_AUTORANGE_EN
      auto_q   <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      dec_q    <= dec_d;
      hold_q   <= hold_d;
      act_q    <= act_d;
      range_q  <= range_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      cnt_en_q <= sig_edge & (state_q == S_GATE);
`ifdef FREQ_GATE_AUTORANGE_EN
      auto_q   <= auto_d;
`endif
    end
  end

  assign cnt_en    = cnt_en_q;
  assign ctr_clear = (state_q == S_CLEAR);
  assign ctr_latch = (state_q == S_LATCH);
  assign gate_open = (state_q == S_GATE);
  assign range     = range_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - self-checking bench for freq_gate_ctrl
module tb_freq_gate_ctrl;
`ifdef FREQ_GATE_AUTORANGE_EN
  localparam int GB   = 2;
  localparam bit AUTO = 1'b1;
`else
  localparam int GB   = 10;
  localparam bit AUTO = 1'b0;
`endif
  localparam int HT = 5;
  localparam int TP = 4;

  logic clk, rst, tick_1us, sig_edge, run, ctr_carry, ctr_msd_zero;
  logic [1:0] range_sel, range;
  logic cnt_en, ctr_clear, ctr_latch, gate_open, ovf, busy;

  freq_gate_ctrl #(.GATE_BASE(GB), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst(rst), .tick_1us(tick_1us), .sig_edge(sig_edge), .run(run),
    .range_sel(range_sel), .ctr_carry(ctr_carry), .ctr_msd_zero(ctr_msd_zero),
    .cnt_en(cnt_en), .ctr_clear(ctr_clear), .ctr_latch(ctr_latch),
    .gate_open(gate_open), .range(range), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : tick_gen
    int ph;
    ph = 0;
    tick_1us = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_1us = (ph == TP - 1);
      ph = (ph + 1) % TP;
    end
  end

  typedef struct { logic [1:0] rsel; int per; bit carry; bit last; bit msd; } vec_t;
  typedef struct { int rng; int ovf; int cnt; int len; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks, errors, cyc, auto_m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int pow10(input int r);
    int p;
    p = 1;
    for (int i = 0; i < r; i++) p = p * 10;
    return p;
  endfunction

  // Runs one measurement from ctr_clear to ctr_latch, driving edges/carry.
  task automatic measure(input vec_t v, input int ntick, output int cnt,
                         output int len, output bit laten, output bit ok);
    bit seen_clr;
    int tig;
    cnt = 0; len = 0; tig = 0; laten = 1'b0; ok = 1'b0; seen_clr = 1'b0;
    for (int g = 0; g < 20000; g++) begin
      step();
      if (ctr_clear) begin seen_clr = 1'b1; cnt = 0; len = 0; tig = 0; end
      if (seen_clr) begin
        if (cnt_en) cnt++;
        if (gate_open) len++;
        if (gate_open && tick_1us) tig++;
      end
      if (gate_open && len == 5) range_sel = ~range_sel;
      ctr_carry = v.carry && gate_open && (len == 12);
      sig_edge = (v.per != 0 && (cyc % v.per) == 0) ||
                 (v.last && gate_open && tick_1us && tig == ntick) ||
                 (v.last && ctr_latch);
      if (seen_clr && ctr_latch) begin
        laten = cnt_en;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : main
    vec_t v;
    exp_t e;
    int r, cnt, len, n;
    bit laten, ok, bad;
    checks = 0; errors = 0; cyc = 0; auto_m = 3;
    rst = 1'b1; run = 1'b0; sig_edge = 1'b0; ctr_carry = 1'b0;
    ctr_msd_zero = 1'b0; range_sel = 2'd0;
    repeat (3) step();
    check("reset_outputs", int'({cnt_en, ctr_clear, ctr_latch, gate_open, range, ovf, busy}), 0);
    rst = 1'b0;
    step();
    check("idle_busy", int'(busy), 0);

`ifdef FREQ_GATE_AUTORANGE_EN
    vecs.push_back('{2'd0, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 8, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) vecs.push_back('{2'd1, 8, 1'b0, 1'b0, 1'b1});
`else
    vecs.push_back('{2'd1, 8,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 4,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'd2, 40, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{2'd1, 16, 1'b0, 1'b0, 1'b0});
`endif

    run = 1'b1;
    foreach (vecs[i]) begin
      v = vecs[i];
      range_sel = v.rsel;
      ctr_msd_zero = v.msd;
      r = AUTO ? auto_m : int'(v.rsel);
      n = GB * pow10(r);
      e.len = TP * n;
      e.cnt = ((v.per != 0) ? e.len / v.per : 0) + int'(v.last);
      e.rng = r;
      e.ovf = int'(v.carry);
      sb.push_back(e);
      measure(v, n, cnt, len, laten, ok);
      check($sformatf("latch_seen[%0d]", i), int'(ok), 1);
      if (ok && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("edge_count[%0d]", i), cnt, e.cnt);
        check($sformatf("gate_len[%0d]", i), len, e.len);
        if (v.last) check($sformatf("final_edge_at_latch[%0d]", i), int'(laten), 1);
        step();
        sig_edge = 1'b0;
        check($sformatf("range[%0d]", i), int'(range), e.rng);
        check($sformatf("ovf[%0d]", i), int'(ovf), e.ovf);
        check($sformatf("no_cnt_after_close[%0d]", i), int'(cnt_en), 0);
      end
      if (v.carry && auto_m > 0) auto_m--;
      else if (v.msd && auto_m < 3) auto_m++;
    end

    // Reset mid-gate aborts without latch; clear follows rst release.
    ok = 1'b0;
    for (int g = 0; g < 300 && !ok; g++) begin step(); ok = gate_open; end
    check("gate_before_rst", int'(ok), 1);
    repeat (10) step();
    rst = 1'b1;
    step();
    check("rst_mid_gate_outputs", int'({cnt_en, ctr_clear, ctr_latch, gate_open, range, ovf, busy}), 0);
    rst = 1'b0;
    step();
    check("clear_after_rst", int'(ctr_clear), 1);

    // run dropped mid-gate: latch, full hold, then idle with no new clear.
    ok = 1'b0;
    for (int g = 0; g < 300 && !ok; g++) begin step(); ok = gate_open; end
    check("gate_after_rst", int'(ok), 1);
    repeat (10) step();
    run = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 20000 && !ok; g++) begin step(); ok = ctr_latch; end
    check("latch_after_run_drop", int'(ok), 1);
    n = 0;
    for (int g = 0; g < 100; g++) begin
      step();
      n++;
      if (!busy) break;
    end
    check("hold_cycles", n, TP * HT);
    bad = 1'b0;
    for (int g = 0; g < 40; g++) begin
      step();
      if (ctr_clear || busy) bad = 1'b1;
    end
    check("stays_idle", int'(bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
